encode_scan_ctrl: RTL



---
 rtl/encode_scan_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/encode_scan_ctrl.sv
// encode_scan_ctrl: sequencer for the ESFA encode operation.
// Holds a table of NUM_SLOTS array descriptors (arrDef, handle, array_code).
// Each accepted metadata query is matched against the slots one per cycle.
// The first (lowest-index) hit is returned through a valid/ready response.
// Optional feature macro: ENCODE_SCAN_HINT_EN adds a one-entry last-hit cache
// and a hint_hit output that lets a repeated query skip the scan.
module encode_scan_ctrl #(
  parameter int NUM_SLOTS = 8,
  parameter int SLOT_W    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [SLOT_W-1:0] wr_slot,
  input  logic              wr_arrDef,
  input  logic [7:0]        wr_handle,
  input  logic [7:0]        wr_array_code,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [7:0]        req_metadata,
  input  logic              req_isMetadata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_bool,
  output logic [7:0]        rsp_value,
  output logic [7:0]        rsp_context,
  output logic [SLOT_W-1:0] rsp_slot,
  output logic              busy
`ifdef ENCODE_SCAN_HINT_EN
  ,
  output logic              hint_hit
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  // Descriptor table
  logic              arr_def    [NUM_SLOTS];
  logic [7:0]        handle_tab [NUM_SLOTS];
  logic [7:0]        code_tab   [NUM_SLOTS];

  // Captured query and scan position
  logic [SLOT_W-1:0] scan_idx, scan_idx_next;
  logic [7:0]        q_meta, q_meta_next;

  // Registered response fields, held for the whole DONE state
  logic              res_bool, res_bool_next;
  logic [7:0]        res_code, res_code_next;
  logic [SLOT_W-1:0] res_slot, res_slot_next;

  logic              accept;
  logic              in_scope;
  logic              wr_ok;
  logic              slot_hit;
  logic              last_slot;
  logic              hint_match;
  logic [SLOT_W-1:0] hint_sel;

  // The reset gating keeps req_ready low for the whole time rst is asserted
  assign accept    = (state == IDLE) && req_valid && !rst;
  assign in_scope  = req_isMetadata && (req_metadata <= 8'd7);
  assign wr_ok     = wr_en && (32'(wr_slot) < 32'(NUM_SLOTS));
  assign last_slot = (scan_idx == SLOT_W'(NUM_SLOTS - 1));

  // Match the captured query against the slot currently under scan; the query
  // is known to be in scope whenever the FSM is in SCAN
  assign slot_hit  = arr_def[scan_idx] && (handle_tab[scan_idx] == q_meta);

`ifdef ENCODE_SCAN_HINT_EN
  logic              hint_valid;
  logic [7:0]        hint_handle;
  logic [SLOT_W-1:0] hint_slot;
  logic              hint_load;
  logic              hint_load_clobbered;

  assign hint_sel   = hint_slot;
  assign hint_match = hint_valid && (hint_handle == req_metadata) && arr_def[hint_slot];
  assign hint_hit   = accept && in_scope && hint_match;

  assign hint_load  = ((state == SCAN) && slot_hit) || hint_hit;
  assign hint_load_clobbered = wr_ok && (wr_slot == res_slot_next);

  // Remember the most recent hit; a write to the cached slot invalidates it
  always_ff @(posedge clk) begin
    if (rst) begin
      hint_valid  <= 1'b0;
      hint_handle <= 8'd0;
      hint_slot   <= '0;
    end else if (hint_load) begin
      hint_valid  <= !hint_load_clobbered;
      hint_handle <= q_meta_next;
      hint_slot   <= res_slot_next;
    end else if (wr_ok && (wr_slot == hint_slot)) begin
      hint_valid  <= 1'b0;
    end
  end
`else
  assign hint_sel   = '0;
  assign hint_match = 1'b0;
`endif

  // Table writes land at the edge, so a scan reading the same slot this cycle sees the old entry
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        arr_def[i]    <= 1'b0;
        handle_tab[i] <= 8'd0;
        code_tab[i]   <= 8'd0;
      end
    end else if (wr_ok) begin
      arr_def[wr_slot]    <= wr_arrDef;
      handle_tab[wr_slot] <= wr_handle;
      code_tab[wr_slot]   <= wr_array_code;
    end
  end

  // Next-state and response computation for the IDLE/SCAN/DONE sequencer
  always_comb begin
    state_next    = state;
    scan_idx_next = scan_idx;
    q_meta_next   = q_meta;
    res_bool_next = res_bool;
    res_code_next = res_code;
    res_slot_next = res_slot;

    case (state)
      IDLE: begin
        if (accept) begin
          q_meta_next   = req_metadata;
          scan_idx_next = '0;
          res_bool_next = 1'b0;
          res_code_next = 8'd0;
          res_slot_next = '0;
          if (!in_scope) begin
            state_next = DONE;
          end else if (hint_match) begin
            state_next    = DONE;
            res_bool_next = 1'b1;
            res_code_next = code_tab[hint_sel];
            res_slot_next = hint_sel;
          end else begin
            state_next = SCAN;
          end
        end
      end

      SCAN: begin
        if (slot_hit) begin
          state_next    = DONE;
          res_bool_next = 1'b1;
          res_code_next = code_tab[scan_idx];
          res_slot_next = scan_idx;
        end else if (last_slot) begin
          state_next = DONE;
        end else begin
          scan_idx_next = scan_idx + SLOT_W'(1);
        end
      end

      DONE: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, captured query and response registers; reset drops any work in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      scan_idx <= '0;
      q_meta   <= 8'd0;
      res_bool <= 1'b0;
      res_code <= 8'd0;
      res_slot <= '0;
    end else begin
      state    <= state_next;
      scan_idx <= scan_idx_next;
      q_meta   <= q_meta_next;
      res_bool <= res_bool_next;
      res_code <= res_code_next;
      res_slot <= res_slot_next;
    end
  end

  assign req_ready   = (state == IDLE) && !rst;
  assign rsp_valid   = (state == DONE);
  assign busy        = (state != IDLE);
  assign rsp_bool    = res_bool;
  assign rsp_value   = res_code;
  assign rsp_context = res_code;
  assign rsp_slot    = res_slot;

endmodule
